// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch front end: PC select codes,
// memory region nibbles, boot defaults and FSM state constants.
package fetch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned STATE_W = 2;

  localparam logic [SEL_W-1:0] PC_SEQ = 3'd2;
  localparam logic [SEL_W-1:0] PC_ALU = 3'd3;
  localparam logic [SEL_W-1:0] PC_JAL = 3'd4;

  localparam logic [3:0] REGION_BIOS = 4'b0100;
  localparam logic [3:0] REGION_IMEM = 4'b0001;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h4000_0000;
  localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFE;

  localparam logic [STATE_W-1:0] ST_BOOT = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            redirect;
  } next_pc_t;

  // Unstalled next fetch address; unknown select codes fall back to sequential.
  function automatic next_pc_t next_pc(input logic [SEL_W-1:0] sel,
                                       input logic [XLEN-1:0]  pc,
                                       input logic [XLEN-1:0]  alu,
                                       input logic [XLEN-1:0]  jal);
    next_pc_t r;
    r.addr     = pc + XLEN'(4);
    r.redirect = 1'b0;
    case (sel)
      PC_ALU: begin
        r.addr     = alu & ALIGN_MASK;
        r.redirect = 1'b1;
      end
      PC_JAL: begin
        r.addr     = jal;
        r.redirect = 1'b1;
      end
      PC_SEQ:  r.addr = pc + XLEN'(4);
      default: r.addr = pc + XLEN'(4);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module fetch_counters
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cycle_en,
  input  logic            retire_en,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cycle_en)  cycle_cnt   <= cycle_cnt + XLEN'(1);
      if (retire_en) instret_cnt <= instret_cnt + XLEN'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC sequencing and instruction fetch: owns the architectural PC, drives the
// synchronous BIOS/IMEM read address and presents the fetched word to execute.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] PC_sel,
  input  logic [XLEN-1:0]  alu_target,
  input  logic [XLEN-1:0]  jal_target,
  input  logic             stall,
  input  logic [XLEN-1:0]  bios_dout,
  input  logic [XLEN-1:0]  imem_dout,
  output logic [XLEN-1:0]  fetch_addr,
  output logic [XLEN-1:0]  pc_X,
  output logic [XLEN-1:0]  inst_X,
  output logic             valid_X,
  output logic             fetch_fault,
  output logic [XLEN-1:0]  cycle_cnt,
  output logic [XLEN-1:0]  instret_cnt
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [XLEN-1:0]    mem_data;
  logic               unmapped;
  logic               fault_set;
  logic               misaligned;
  next_pc_t           target;

  // Region decode of the PC whose read data is arriving this cycle
  always_comb begin
    mem_data = NOP_INST;
    unmapped = 1'b0;
    case (pc_X[31:28])
      REGION_BIOS: mem_data = bios_dout;
      REGION_IMEM: mem_data = imem_dout;
      default:     unmapped = 1'b1;
    endcase
  end

  assign target     = next_pc(PC_sel, pc_X, alu_target, jal_target);
  assign misaligned = target.redirect && target.addr[1];

  // Next state, fetch address and execute-stage outputs
  always_comb begin
    state_next = state;
    fetch_addr = pc_X;
    valid_X    = 1'b0;
    inst_X     = NOP_INST;
    fault_set  = 1'b0;
    case (state)
      ST_BOOT: begin
        fetch_addr = RESET_PC;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (unmapped) begin
          fault_set  = 1'b1;
          state_next = ST_HALT;
        end else begin
          valid_X = 1'b1;
          inst_X  = mem_data;
          // A stall refetches pc_X so the memory output stays put
          if (stall) begin
            fetch_addr = pc_X;
          end else if (misaligned) begin
            fault_set  = 1'b1;
            state_next = ST_HALT;
          end else begin
            fetch_addr = target.addr;
          end
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: begin
        fetch_addr = RESET_PC;
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc_X        <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_next;
      pc_X  <= fetch_addr;
      if (fault_set) fetch_fault <= 1'b1;
    end
  end

  fetch_counters u_counters (
    .clk         (clk),
    .rst         (rst),
    .cycle_en    (1'b1),
    .retire_en   (valid_X && !stall),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency BIOS/IMEM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  PC_sel;
  logic [31:0] alu_target;
  logic [31:0] jal_target;
  logic        stall;
  logic [31:0] bios_dout;
  logic [31:0] imem_dout;
  logic [31:0] fetch_addr;
  logic [31:0] pc_X;
  logic [31:0] inst_X;
  logic        valid_X;
  logic        fetch_fault;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .PC_sel      (PC_sel),
    .alu_target  (alu_target),
    .jal_target  (jal_target),
    .stall       (stall),
    .bios_dout   (bios_dout),
    .imem_dout   (imem_dout),
    .fetch_addr  (fetch_addr),
    .pc_X        (pc_X),
    .inst_X      (inst_X),
    .valid_X     (valid_X),
    .fetch_fault (fetch_fault),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  // Memory contents tag each word with its address low bits
  function automatic logic [31:0] bios_word(input logic [31:0] a);
    return {a[11:0], 20'h00093};
  endfunction

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[11:0], 20'h00113};
  endfunction

  always @(posedge clk) begin
    bios_dout <= bios_word(fetch_addr);
    imem_dout <= imem_word(fetch_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; PC_sel = 3'd2; stall = 1'b0; alu_target = '0; jal_target = '0;
    tick(); tick();
    checks++; if (pc_X !== RST_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc_X, RST_PC); end
    checks++; if (inst_X !== NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", inst_X, NOP); end
    checks++; if (valid_X !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_X); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", fetch_fault); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL rst_cycle got=%0d exp=0", cycle_cnt); end
    checks++; if (instret_cnt !== 32'd0) begin failures++; $display("FAIL rst_instret got=%0d exp=0", instret_cnt); end
    checks++; if (fetch_addr !== RST_PC) begin failures++; $display("FAIL rst_faddr got=%h exp=%h", fetch_addr, RST_PC); end
    rst = 1'b0;
    #1;
    checks++; if (valid_X !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", valid_X); end
    checks++; if (fetch_addr !== RST_PC) begin failures++; $display("FAIL boot_faddr got=%h exp=%h", fetch_addr, RST_PC); end
  endtask

  task automatic test_first_fetch();
    tick();
    checks++; if (valid_X !== 1'b1) begin failures++; $display("FAIL ff_valid got=%b exp=1", valid_X); end
    checks++; if (pc_X !== 32'h4000_0000) begin failures++; $display("FAIL ff_pc got=%h exp=40000000", pc_X); end
    checks++; if (inst_X !== 32'h0000_0093) begin failures++; $display("FAIL ff_inst got=%h exp=00000093", inst_X); end
    checks++; if (fetch_addr !== 32'h4000_0004) begin failures++; $display("FAIL ff_faddr got=%h exp=40000004", fetch_addr); end
    checks++; if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL ff_cycle got=%0d exp=1", cycle_cnt); end
  endtask

  task automatic test_jal_redirect();
    tick(); tick();
    checks++; if (pc_X !== 32'h4000_0008) begin failures++; $display("FAIL jal_pre_pc got=%h exp=40000008", pc_X); end
    PC_sel = 3'd4; jal_target = 32'h1000_0010;
    #1;
    checks++; if (fetch_addr !== 32'h1000_0010) begin failures++; $display("FAIL jal_faddr got=%h exp=10000010", fetch_addr); end
    tick();
    checks++; if (pc_X !== 32'h1000_0010) begin failures++; $display("FAIL jal_pc got=%h exp=10000010", pc_X); end
    checks++; if (inst_X !== 32'h0100_0113) begin failures++; $display("FAIL jal_inst got=%h exp=01000113", inst_X); end
    checks++; if (valid_X !== 1'b1) begin failures++; $display("FAIL jal_valid got=%b exp=1", valid_X); end
  endtask

  task automatic test_alu_redirect();
    PC_sel = 3'd3; alu_target = 32'h4000_0021;
    #1;
    checks++; if (fetch_addr !== 32'h4000_0020) begin failures++; $display("FAIL alu_faddr got=%h exp=40000020", fetch_addr); end
    tick();
    checks++; if (pc_X !== 32'h4000_0020) begin failures++; $display("FAIL alu_pc got=%h exp=40000020", pc_X); end
    checks++; if (inst_X !== 32'h0200_0093) begin failures++; $display("FAIL alu_inst got=%h exp=02000093", inst_X); end
  endtask

  task automatic test_stall();
    stall = 1'b1; PC_sel = 3'd3; alu_target = 32'h1000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fetch_addr !== 32'h4000_0020) begin failures++; $display("FAIL stall_faddr[%0d] got=%h exp=40000020", i, fetch_addr); end
      checks++; if (pc_X !== 32'h4000_0020) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=40000020", i, pc_X); end
      checks++; if (inst_X !== 32'h0200_0093) begin failures++; $display("FAIL stall_inst[%0d] got=%h exp=02000093", i, inst_X); end
      tick();
    end
    stall = 1'b0; PC_sel = 3'd2;
    #1;
    checks++; if (pc_X !== 32'h4000_0020) begin failures++; $display("FAIL stall_hold_pc got=%h exp=40000020", pc_X); end
    checks++; if (instret_cnt !== 32'd4) begin failures++; $display("FAIL stall_instret_mid got=%0d exp=4", instret_cnt); end
    tick();
    checks++; if (pc_X !== 32'h4000_0024) begin failures++; $display("FAIL stall_rel_pc got=%h exp=40000024", pc_X); end
    checks++; if (instret_cnt !== 32'd5) begin failures++; $display("FAIL stall_instret got=%0d exp=5", instret_cnt); end
    checks++; if (cycle_cnt !== 32'd9) begin failures++; $display("FAIL stall_cycle got=%0d exp=9", cycle_cnt); end
  endtask

  task automatic test_misaligned_fault();
    PC_sel = 3'd3; alu_target = 32'h4000_0022;
    #1;
    checks++; if (fetch_addr !== 32'h4000_0024) begin failures++; $display("FAIL mis_faddr got=%h exp=40000024", fetch_addr); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL mis_pre_fault got=%b exp=0", fetch_fault); end
    tick();
    PC_sel = 3'd4; jal_target = 32'h1000_0000;
    #1;
    checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL mis_fault got=%b exp=1", fetch_fault); end
    checks++; if (valid_X !== 1'b0) begin failures++; $display("FAIL mis_valid got=%b exp=0", valid_X); end
    checks++; if (inst_X !== NOP) begin failures++; $display("FAIL mis_inst got=%h exp=%h", inst_X, NOP); end
    checks++; if (pc_X !== 32'h4000_0024) begin failures++; $display("FAIL mis_pc got=%h exp=40000024", pc_X); end
    checks++; if (fetch_addr !== 32'h4000_0024) begin failures++; $display("FAIL halt_faddr got=%h exp=40000024", fetch_addr); end
    checks++; if (instret_cnt !== 32'd6) begin failures++; $display("FAIL mis_instret got=%0d exp=6", instret_cnt); end
    tick();
    checks++; if (valid_X !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", valid_X); end
    checks++; if (pc_X !== 32'h4000_0024) begin failures++; $display("FAIL halt_pc got=%h exp=40000024", pc_X); end
    checks++; if (instret_cnt !== 32'd6) begin failures++; $display("FAIL halt_instret got=%0d exp=6", instret_cnt); end
  endtask

  task automatic test_unmapped_fault();
    rst = 1'b1; PC_sel = 3'd2; stall = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tick();
    PC_sel = 3'd4; jal_target = 32'h1FFF_FFF8;
    #1;
    checks++; if (fetch_addr !== 32'h1FFF_FFF8) begin failures++; $display("FAIL um_faddr got=%h exp=1ffffff8", fetch_addr); end
    tick();
    PC_sel = 3'd2;
    #1;
    checks++; if (inst_X !== 32'hFF80_0113) begin failures++; $display("FAIL um_imem_inst got=%h exp=ff800113", inst_X); end
    tick(); tick();
    checks++; if (pc_X !== 32'h2000_0000) begin failures++; $display("FAIL um_pc got=%h exp=20000000", pc_X); end
    checks++; if (valid_X !== 1'b0) begin failures++; $display("FAIL um_valid got=%b exp=0", valid_X); end
    checks++; if (inst_X !== NOP) begin failures++; $display("FAIL um_inst got=%h exp=%h", inst_X, NOP); end
    tick();
    checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL um_fault got=%b exp=1", fetch_fault); end
    checks++; if (pc_X !== 32'h2000_0000) begin failures++; $display("FAIL um_halt_pc got=%h exp=20000000", pc_X); end
    checks++; if (instret_cnt !== 32'd3) begin failures++; $display("FAIL um_instret got=%0d exp=3", instret_cnt); end
    checks++; if (cycle_cnt !== 32'd5) begin failures++; $display("FAIL um_cycle got=%0d exp=5", cycle_cnt); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rst2_fault got=%b exp=0", fetch_fault); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL rst2_cycle got=%0d exp=0", cycle_cnt); end
    checks++; if (instret_cnt !== 32'd0) begin failures++; $display("FAIL rst2_instret got=%0d exp=0", instret_cnt); end
    checks++; if (pc_X !== RST_PC) begin failures++; $display("FAIL rst2_pc got=%h exp=%h", pc_X, RST_PC); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (valid_X !== 1'b0) begin failures++; $display("FAIL rst2_boot_valid got=%b exp=0", valid_X); end
    checks++; if (fetch_addr !== RST_PC) begin failures++; $display("FAIL rst2_boot_faddr got=%h exp=%h", fetch_addr, RST_PC); end
  endtask

  task automatic test_long_run();
    stall = 1'b1; PC_sel = 3'd7;
    tick();
    stall = 1'b0;
    #1;
    checks++; if (valid_X !== 1'b1) begin failures++; $display("FAIL lr_boot_stall got=%b exp=1", valid_X); end
    checks++; if (fetch_addr !== 32'h4000_0004) begin failures++; $display("FAIL lr_sel7_faddr got=%h exp=40000004", fetch_addr); end
    for (int i = 1; i <= 100; i++) begin
      PC_sel = (i % 2 == 1) ? 3'd0 : 3'd5;
      tick();
    end
    checks++; if (cycle_cnt !== 32'd101) begin failures++; $display("FAIL lr_cycle got=%0d exp=101", cycle_cnt); end
    checks++; if (instret_cnt !== 32'd100) begin failures++; $display("FAIL lr_instret got=%0d exp=100", instret_cnt); end
    checks++; if (pc_X !== 32'h4000_0190) begin failures++; $display("FAIL lr_pc got=%h exp=40000190", pc_X); end
    checks++; if (inst_X !== 32'h1900_0093) begin failures++; $display("FAIL lr_inst got=%h exp=19000093", inst_X); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_jal_redirect();
    test_alu_redirect();
    test_stall();
    test_misaligned_fault();
    test_unmapped_fault();
    test_long_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC sequencing block for the three-stage pipeline, on the receiving end of the control unit's `PC_sel` output. It owns the architectural PC and computes the next fetch address from `PC_sel` and the ALU/JAL targets. It drives the synchronous BIOS/IMEM read address and hands the returned instruction, with its PC, to the execute stage. It also handles the boot bubble, stalls, fetch faults (halting the front end), and the cycle/instret counters.

## Interface
- `RESET_PC`, 32'h4000_0000, first fetch address (BIOS base).
- `NOP_INST`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `PC_sel`  in  3  from control unit:
  - 2 = sequential; 3 = ALU target; 4 = JAL target.
  - Any other value is treated as 2.
- `alu_target`  in  32  branch/JALR target.
- `jal_target`  in  32  JAL target.
- `stall`  in  1  hold execute stage.
- `bios_dout`  in  32  BIOS read data for the address presented last cycle.
- `imem_dout`  in  32  IMEM read data for the address presented last cycle.
- `fetch_addr`  out  32  combinational read address to BIOS and IMEM.
- `pc_X`  out  32  PC of the instruction in execute.
- `inst_X`  out  32  instruction in execute.
- `valid_X`  out  1  `inst_X` is real, not a bubble.
- `fetch_fault`  out  1  sticky; misaligned target or unmapped fetch region.
- `cycle_cnt`  out  32  cycles since reset.
- `instret_cnt`  out  32  retired instructions.

## Operation
- FSM states: BOOT, RUN, HALT. Reset state is BOOT.
- Reset values:
  - `pc_X` = `RESET_PC`.
  - `valid_X`, `fetch_fault`, `cycle_cnt`, `instret_cnt` = 0.
  - `inst_X` = `NOP_INST`.
  - `fetch_addr` = `RESET_PC`.
- BOOT:
  - `fetch_addr` = `RESET_PC`; `valid_X` = 0.
  - Next state is RUN unconditionally, ignoring `stall`.
- RUN, region decode on `pc_X[31:28]`:
  - 4'b0100 selects `bios_dout`.
  - 4'b0001 selects `imem_dout`.
  - Any other value is a fault.
- RUN outputs: `valid_X` = 1 and `inst_X` = selected data, unless faulting.
- Next-address rule in RUN, in priority order:
  - `stall` → `pc_X`. This refetch keeps the memory output stable. `PC_sel` is ignored.
  - `PC_sel`=3 → `{alu_target[31:1],1'b0}`.
  - `PC_sel`=4 → `jal_target`.
  - Otherwise → `pc_X+4`, modulo 2^32 (wraps).
- `pc_X <= fetch_addr` every cycle.
- Fault in RUN:
  - Trigger: chosen target has bit[1]=1 (3 or 4, no stall), or `pc_X` is in an unmapped region.
  - `fetch_fault <= 1`; next state HALT.
  - For a misaligned target, `pc_X` does not advance.
  - For an unmapped `pc_X`, `valid_X` = 0 and `inst_X` = `NOP_INST` in that same cycle.
- HALT:
  - `valid_X` = 0; `inst_X` = `NOP_INST`; `fetch_addr` = `pc_X` (frozen).
  - Only `rst` exits.
- Counters:
  - `cycle_cnt` increments every cycle outside reset.
  - `instret_cnt` increments when `valid_X && !stall`.
  - Both wrap at 2^32.
- Reset asserted mid-operation:
  - All registers return to their reset values immediately.
  - Any memory data in flight is discarded.

## Timing
- Read latency is one cycle: the address presented in cycle N has its data in `inst_X` in cycle N+1.
- Redirect penalty is zero. The target is fetched in the same cycle `PC_sel` is decoded.
- First cycle after `rst` deasserts is BOOT (bubble). The first valid instruction, at `RESET_PC`, appears one cycle later.
- Stall lasting k cycles: `inst_X`/`pc_X` are held for k+1 cycles and `instret_cnt` counts once.
- `stall` together with `PC_sel`=3 or 4: the stall wins, and the redirect must be re-presented by the control unit after the stall releases.
- `fetch_addr` is a combinational path from `PC_sel`, the targets and `stall`. It has no registered copy.

## Structure
- Shared package (extend `Opcode.vh` or a companion header):
  - `PC_sel` encodings: PC_SEQ=2, PC_ALU=3, PC_JAL=4.
  - Region nibbles: BIOS=4'b0100, IMEM=4'b0001.
  - `RESET_PC` and `NOP_INST` defaults.
  - FSM state encodings.
- One natural sub-module: `fetch_counters` (`cycle_cnt`/`instret_cnt`, enable and async reset).
- The next-PC mux and FSM stay in `fetch_unit`.

## Test plan
- Reset release, bios_dout=32'h00000093 → cycle 0: `valid_X`=0, `fetch_addr`=4000_0000; cycle 1: `valid_X`=1, `pc_X`=4000_0000, `inst_X`=00000093, `fetch_addr`=4000_0004.
- `PC_sel`=4, `jal_target`=1000_0010 at `pc_X`=4000_0008 → next cycle `pc_X`=1000_0010, `inst_X`=`imem_dout`.
- `PC_sel`=3, `alu_target`=4000_0021 → `fetch_addr`=4000_0020 (bit0 cleared). `alu_target`=4000_0022 → `fetch_fault`=1, HALT, `valid_X`=0 thereafter.
- `stall`=1 for 3 cycles with `PC_sel`=3 → `pc_X` constant for 4 cycles, no redirect, `instret_cnt`+1 only.
- Sequential fetch reaching `pc_X`=2000_0000 → `fetch_fault`=1, `inst_X`=00000013; `rst` pulse mid-HALT → BOOT, counters 0, `fetch_fault`=0.
- 100 unstalled RUN cycles → `cycle_cnt`=101, `instret_cnt`=100.
